mips_multicycle_ctrl: RTL
=========================

Name: mips_multicycle_ctrl

Overview:
- Multi-cycle control FSM for the MIPS datapath. It replaces per-instruction single-cycle decode with a state sequence (fetch, decode, execute, memory, writeback) over one shared ALU and one shared instruction/data memory.
- It reads the opcode/func fields of the instruction register and drives the datapath mux, enable and ALU selects each cycle.
- Every memory access uses a ready handshake, so slow memory stalls the FSM.

Parameters:
- OP_RT, 6'd0, R-type opcode
- OP_LW, 6'd35, load word
- OP_SW, 6'd43, store word
- OP_BEQ, 6'd4, branch equal
- OP_BNE, 6'd5, branch not equal
- OP_J, 6'd2, jump
- OP_JAL, 6'd3, jump and link
- OP_ADDI, 6'd8, add immediate
- OP_SLTI, 6'd10, set-less-than immediate
- F_ADD, 6'd32; F_SUB, 6'd34; F_SLT, 6'd42; F_JR, 6'd8: R-type func codes

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- op  in  6  IR[31:26]; stable from the cycle after ir_write
- func  in  6  IR[5:0]
- zero  in  1  ALU zero flag, same cycle
- mem_ready  in  1  memory completes the current read/write this cycle
- pc_write  out  1  PC load enable
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  instruction register load
- reg_write  out  1  register file write
- reg_dst  out  2  write register select: 0 = rt, 1 = rd, 2 = r31
- mem_to_reg  out  2  write data select: 0 = ALUOut, 1 = MDR, 2 = PC
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = regA
- alu_src_b  out  2  ALU B select: 0 = regB, 1 = 4, 2 = sign-extended imm, 3 = imm<<2
- alu_op  out  3  ALU function: 0 = ADD, 1 = SUB, 2 = SLT
- pc_src  out  2  PC input select: 0 = ALU result, 1 = ALUOut, 2 = jump address, 3 = regA
- instr_done  out  1  one-cycle pulse in the final cycle of each instruction
- trap  out  1  illegal instruction; held high
- state  out  4  current state, for debug

Behaviour:
- Clock/reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- rst_n low: state goes to IDLE immediately, including mid-instruction. Every output is 0 while in IDLE. No writes are issued.
- All outputs are decoded from the state. pc_write in BRANCH and the FETCH/MEM handshake signals also depend on zero, op or mem_ready as stated below. Any signal not listed for a state is 0.
- State encoding: IDLE=0, FETCH=1, DECODE=2, MEM_ADR=3, MEM_RD=4, WB_MEM=5, MEM_WR=6, EX_R=7, WB_R=8, EX_I=9, WB_I=10, BRANCH=11, JUMP=12, JAL=13, JR=14, TRAP=15.
- IDLE -> FETCH unconditionally on the first edge after reset is released.
- FETCH:
  - Drives mem_read=1, iord=0, alu_src_a=0, alu_src_b=1, alu_op=ADD, pc_src=0.
  - If mem_ready is 1: ir_write=1, pc_write=1, next state DECODE.
  - Otherwise hold in FETCH with ir_write and pc_write at 0.
- DECODE: alu_src_a=0, alu_src_b=3, alu_op=ADD (branch target into ALUOut). Dispatch:
  - lw/sw -> MEM_ADR
  - R-type with F_ADD, F_SUB or F_SLT -> EX_R
  - R-type with F_JR -> JR
  - addi/slti -> EX_I
  - beq/bne -> BRANCH
  - j -> JUMP
  - jal -> JAL
  - anything else -> TRAP
- MEM_ADR: alu_src_a=1, alu_src_b=2, ADD. Next state MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_read=1, iord=1. Hold until mem_ready, then WB_MEM.
- WB_MEM: reg_write=1, reg_dst=0, mem_to_reg=1, instr_done=1. Next state FETCH.
- MEM_WR: mem_write=1, iord=1. Hold until mem_ready; in the mem_ready cycle instr_done=1 and next state FETCH.
- EX_R: alu_src_a=1, alu_src_b=0, alu_op = ADD/SUB/SLT according to func. Next state WB_R.
- WB_R: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1. Next state FETCH.
- EX_I: alu_src_a=1, alu_src_b=2, alu_op = ADD for addi, SLT for slti. Next state WB_I.
- WB_I: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1. Next state FETCH.
- BRANCH: alu_src_a=1, alu_src_b=0, SUB, pc_src=1, instr_done=1. pc_write = (op==OP_BEQ & zero) | (op==OP_BNE & ~zero). Next state FETCH.
- JUMP: pc_src=2, pc_write=1, instr_done=1. Next state FETCH.
- JAL: reg_write=1, reg_dst=2, mem_to_reg=2 (PC already holds PC+4), pc_src=2, pc_write=1, instr_done=1. Next state FETCH.
- JR: pc_src=3, pc_write=1, instr_done=1. Next state FETCH.
- TRAP: trap=1, all other outputs 0. Stays in TRAP until rst_n is asserted.
- Latency with mem_ready tied high, in cycles from FETCH to the end of instr_done:
  - R-type, addi/slti, sw: 4
  - lw: 5
  - beq/bne, j, jal, jr: 3
- Each cycle of mem_ready=0 in FETCH, MEM_RD or MEM_WR adds one cycle. Request signals stay asserted and stable during a stall.
- mem_read and mem_write are never high in the same cycle. ir_write occurs only in FETCH.

Test Plan:
- Reset: rst_n=0 mid-EX_R -> state=0 and all outputs 0 within the same cycle. After release: IDLE, then FETCH with mem_read=1.
- add (op 0, func 32), mem_ready=1 -> states 1,2,7,8. In state 8: reg_write=1, reg_dst=1. instr_done pulses exactly once; back to FETCH after 4 cycles.
- lw (op 35), mem_ready low for 2 cycles in MEM_RD -> MEM_RD held 3 cycles with iord=1, mem_read=1. Then WB_MEM with mem_to_reg=1, reg_write=1. Total 7 cycles.
- beq with zero=1 -> pc_write=1, pc_src=1 in BRANCH. Same test with zero=0 -> pc_write=0. Repeat for bne with the opposite results.
- jal (op 3) -> JAL state: reg_dst=2, mem_to_reg=2, reg_write=1, pc_src=2, pc_write=1. jr (op 0, func 8) -> JR state: pc_src=3, pc_write=1.
- Illegal op 6'd63 -> TRAP after DECODE: trap=1, no further pc_write or mem_read. Asserting rst_n=0 clears it.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// over a shared ALU and memory, stalling on the memory ready handshake.
module mips_multicycle_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic [1:0] pc_src,
  output logic       instr_done,
  output logic       trap,
  output logic [3:0] state
);

  localparam logic [5:0] OP_RT   = 6'd0;
  localparam logic [5:0] OP_LW   = 6'd35;
  localparam logic [5:0] OP_SW   = 6'd43;
  localparam logic [5:0] OP_BEQ  = 6'd4;
  localparam logic [5:0] OP_BNE  = 6'd5;
  localparam logic [5:0] OP_J    = 6'd2;
  localparam logic [5:0] OP_JAL  = 6'd3;
  localparam logic [5:0] OP_ADDI = 6'd8;
  localparam logic [5:0] OP_SLTI = 6'd10;
  localparam logic [5:0] F_ADD   = 6'd32;
  localparam logic [5:0] F_SUB   = 6'd34;
  localparam logic [5:0] F_SLT   = 6'd42;
  localparam logic [5:0] F_JR    = 6'd8;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_SLT = 3'd2;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEM_ADR = 4'd3,
    S_MEM_RD  = 4'd4,
    S_WB_MEM  = 4'd5,
    S_MEM_WR  = 4'd6,
    S_EX_R    = 4'd7,
    S_WB_R    = 4'd8,
    S_EX_I    = 4'd9,
    S_WB_I    = 4'd10,
    S_BRANCH  = 4'd11,
    S_JUMP    = 4'd12,
    S_JAL     = 4'd13,
    S_JR      = 4'd14,
    S_TRAP    = 4'd15
  } state_t;

  state_t r_state;
  state_t w_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  assign state = r_state;

  always_comb begin
    w_next     = r_state;
    pc_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = '0;
    mem_to_reg = '0;
    alu_src_a  = 1'b0;
    alu_src_b  = '0;
    alu_op     = ALU_ADD;
    pc_src     = '0;
    instr_done = 1'b0;
    trap       = 1'b0;

    case (r_state)
      S_IDLE: w_next = S_FETCH;

      // PC+4 is computed in the ALU while the instruction is read.
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'd1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          w_next   = S_DECODE;
        end
      end

      S_DECODE: begin
        alu_src_b = 2'd3;
        case (op)
          OP_LW, OP_SW:     w_next = S_MEM_ADR;
          OP_RT: begin
            if (func == F_ADD || func == F_SUB || func == F_SLT) w_next = S_EX_R;
            else if (func == F_JR)                               w_next = S_JR;
            else                                                 w_next = S_TRAP;
          end
          OP_ADDI, OP_SLTI: w_next = S_EX_I;
          OP_BEQ, OP_BNE:   w_next = S_BRANCH;
          OP_J:             w_next = S_JUMP;
          OP_JAL:           w_next = S_JAL;
          default:          w_next = S_TRAP;
        endcase
      end

      S_MEM_ADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        w_next    = (op == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end

      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready) w_next = S_WB_MEM;
      end

      S_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'd1;
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end

      S_MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          w_next     = S_FETCH;
        end
      end

      S_EX_R: begin
        alu_src_a = 1'b1;
        case (func)
          F_SUB:   alu_op = ALU_SUB;
          F_SLT:   alu_op = ALU_SLT;
          default: alu_op = ALU_ADD;
        endcase
        w_next = S_WB_R;
      end

      S_WB_R: begin
        reg_write  = 1'b1;
        reg_dst    = 2'd1;
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end

      S_EX_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        alu_op    = (op == OP_SLTI) ? ALU_SLT : ALU_ADD;
        w_next    = S_WB_I;
      end

      S_WB_I: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end

      // Target already sits in ALUOut from DECODE; the ALU compares regA/regB.
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = ALU_SUB;
        pc_src     = 2'd1;
        instr_done = 1'b1;
        pc_write   = ((op == OP_BEQ) && zero) || ((op == OP_BNE) && !zero);
        w_next     = S_FETCH;
      end

      S_JUMP: begin
        pc_src     = 2'd2;
        pc_write   = 1'b1;
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end

      S_JAL: begin
        reg_write  = 1'b1;
        reg_dst    = 2'd2;
        mem_to_reg = 2'd2;
        pc_src     = 2'd2;
        pc_write   = 1'b1;
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end

      S_JR: begin
        pc_src     = 2'd3;
        pc_write   = 1'b1;
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end

      S_TRAP: trap = 1'b1;

      default: w_next = S_IDLE;
    endcase
  end

endmodule
